// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_pipe_reg
//  Purpose  : ID/EX pipeline register with a valid/ready handshake, built on a
//             2-entry skid buffer (main + skid) so that the upstream ready is
//             driven from registered state. Supports flush and bubble gating.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk_i, rst_n_i            clock (rising edge), async active-low reset
//    flush_i                   kill both held entries at the next edge
//    in_valid_i / in_ready_o   decode-side handshake
//    WB_i, MEM_i, EX_i         control fields
//    RS1_i, RS2_i, IMM_i       operands and immediate
//    RS1addr_i, RS2addr_i,
//    RDaddr_i, funct_i         register addresses and funct bits
//    out_valid_o / out_ready_i execute-side handshake
//    WB_o, MEM_o, ALUSrc_o,
//    ALUOp_o                   controls, forced to 0 while out_valid_o = 0
//    RS1_o .. funct_o          held payload of the main entry
//    hazard_o                  load-use stall indication
//
//  Build option
//    ID_EX_LOAD_USE_DETECT_EN  enables internal load-use detection; when
//                              undefined hazard_o is tied to 0.
// ============================================================================
module id_ex_pipe_reg #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int FUNCT_W = 10,
   parameter int WB_W    = 2,
   parameter int MEM_W   = 2,
   parameter int EX_W    = 3
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               flush_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WB_W-1:0]    WB_i,
   input  logic [MEM_W-1:0]   MEM_i,
   input  logic [EX_W-1:0]    EX_i,
   input  logic [DATA_W-1:0]  RS1_i,
   input  logic [DATA_W-1:0]  RS2_i,
   input  logic [DATA_W-1:0]  IMM_i,
   input  logic [REG_AW-1:0]  RS1addr_i,
   input  logic [REG_AW-1:0]  RS2addr_i,
   input  logic [REG_AW-1:0]  RDaddr_i,
   input  logic [FUNCT_W-1:0] funct_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [WB_W-1:0]    WB_o,
   output logic [MEM_W-1:0]   MEM_o,
   output logic               ALUSrc_o,
   output logic [EX_W-2:0]    ALUOp_o,
   output logic [DATA_W-1:0]  RS1_o,
   output logic [DATA_W-1:0]  RS2_o,
   output logic [DATA_W-1:0]  IMM_o,
   output logic [REG_AW-1:0]  RS1addr_o,
   output logic [REG_AW-1:0]  RS2addr_o,
   output logic [REG_AW-1:0]  RDaddr_o,
   output logic [FUNCT_W-1:0] funct_o,
   output logic               hazard_o
);

   localparam int PW = WB_W + MEM_W + EX_W + 3*DATA_W + 3*REG_AW + FUNCT_W;

   logic [PW-1:0] in_pl;
   logic [PW-1:0] main_q, main_d;
   logic [PW-1:0] skid_q, skid_d;
   logic          main_v_q, main_v_d;
   logic          skid_v_q, skid_v_d;
   logic          in_fire;
   logic          out_fire;

   logic [WB_W-1:0]  main_wb;
   logic [MEM_W-1:0] main_mem;
   logic [EX_W-1:0]  main_ex;

   assign in_pl = {WB_i, MEM_i, EX_i, RS1_i, RS2_i, IMM_i,
                   RS1addr_i, RS2addr_i, RDaddr_i, funct_i};

   assign {main_wb, main_mem, main_ex, RS1_o, RS2_o, IMM_o,
           RS1addr_o, RS2addr_o, RDaddr_o, funct_o} = main_q;

`ifdef ID_EX_LOAD_USE_DETECT_EN
   // A load in main whose destination feeds the instruction waiting in decode
   // must not be overtaken; x0 is never a real dependency.
   assign hazard_o = in_valid_i & main_v_q & main_mem[MEM_W-1] &
                     (RDaddr_o != '0) &
                     ((RDaddr_o == RS1addr_i) | (RDaddr_o == RS2addr_i));
`else
   assign hazard_o = 1'b0;
`endif

   assign in_ready_o  = ~skid_v_q & ~hazard_o;
   assign out_valid_o = main_v_q;
   assign in_fire     = in_valid_i & in_ready_o;
   assign out_fire    = main_v_q & out_ready_i;

   // Bubble gating: an invalid slot can never write the register file or memory.
   assign WB_o     = main_v_q ? main_wb             : '0;
   assign MEM_o    = main_v_q ? main_mem            : '0;
   assign ALUSrc_o = main_v_q ? main_ex[0]          : 1'b0;
   assign ALUOp_o  = main_v_q ? main_ex[EX_W-1:1]   : '0;

   always_comb begin
      main_d   = main_q;
      skid_d   = skid_q;
      main_v_d = main_v_q;
      skid_v_d = skid_v_q;
      if (flush_i) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (!main_v_q || out_fire) begin
         // Main is free this cycle: the older skid entry has priority. While
         // skid is full in_ready_o is low, so no input can be lost here.
         if (skid_v_q) begin
            main_d   = skid_q;
            main_v_d = 1'b1;
            skid_v_d = 1'b0;
         end else if (in_fire) begin
            main_d   = in_pl;
            main_v_d = 1'b1;
         end else begin
            main_v_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_d   = in_pl;
         skid_v_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_pipe_reg
//  Purpose  : Self-checking bench for id_ex_pipe_reg. Accepted inputs are
//             pushed into an expected-output queue; a monitor pops and
//             compares on every output handshake and checks bubble gating.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_reg;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        flush_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [1:0]  WB_i, MEM_i;
   logic [2:0]  EX_i;
   logic [31:0] RS1_i, RS2_i, IMM_i;
   logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;
   logic [9:0]  funct_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [1:0]  WB_o, MEM_o;
   logic        ALUSrc_o;
   logic [1:0]  ALUOp_o;
   logic [31:0] RS1_o, RS2_o, IMM_o;
   logic [4:0]  RS1addr_o, RS2addr_o, RDaddr_o;
   logic [9:0]  funct_o;
   logic        hazard_o;

   id_ex_pipe_reg dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .WB_i(WB_i), .MEM_i(MEM_i), .EX_i(EX_i),
      .RS1_i(RS1_i), .RS2_i(RS2_i), .IMM_i(IMM_i),
      .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
      .funct_i(funct_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .WB_o(WB_o), .MEM_o(MEM_o), .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
      .RS1_o(RS1_o), .RS2_o(RS2_o), .IMM_o(IMM_o),
      .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
      .funct_o(funct_o), .hazard_o(hazard_o)
   );

   always #5 clk_i = ~clk_i;

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [127:0] sb[$];
   logic [127:0] drv_vec;
   logic         flush_pend = 1'b0;

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares every output handshake against the queue head.
   logic [127:0] out_vec;
   assign out_vec = {WB_o, MEM_o, ALUOp_o, ALUSrc_o, RS1_o, RS2_o, IMM_o,
                     RS1addr_o, RS2addr_o, RDaddr_o, funct_o};

   always @(negedge clk_i) begin
      if (rst_n_i === 1'b1) begin
         if (out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_unexpected: got rd=%0d expected no output", RDaddr_o);
            end else begin
               check("sb_payload", out_vec, sb.pop_front());
            end
         end else if (!out_valid_o) begin
            check("bubble_ctrl", {121'd0, WB_o, MEM_o, ALUSrc_o, ALUOp_o}, 128'd0);
         end
      end
   end

   // Drive one cycle's inputs (called at posedge+1); payload derived from rd.
   task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [1:0] mem,
                        input logic ordy, input logic fl);
      if (flush_pend) begin
         sb.delete();
         flush_pend = 1'b0;
      end
      in_valid_i  = v;
      RDaddr_i    = rd;
      RS1addr_i   = a1;
      RS2addr_i   = a2;
      MEM_i       = mem;
      WB_i        = 2'b01;
      EX_i        = rd[2:0];
      RS1_i       = 32'hA000_0000 | {27'd0, rd};
      RS2_i       = 32'hB000_0000 | {27'd0, rd};
      IMM_i       = 32'hC000_0000 | {27'd0, rd};
      funct_i     = {5'h15, rd};
      out_ready_i = ordy;
      flush_i     = fl;
      drv_vec = {WB_i, MEM_i, EX_i, RS1_i, RS2_i, IMM_i,
                 RS1addr_i, RS2addr_i, RDaddr_i, funct_i};
      #1;
   endtask

   // Finish the cycle: record acceptance, advance to posedge+1.
   task automatic step();
      #1;
      if (flush_i) flush_pend = 1'b1;
      else if (in_valid_i && in_ready_o) sb.push_back(drv_vec);
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, ordy, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_i = 1'b0;
      idle(1'b1);
      // Reset state
      check("rst_out_valid", {127'd0, out_valid_o}, 128'd0);
      check("rst_in_ready",  {127'd0, in_ready_o},  128'd1);
      check("rst_outputs",   out_vec, 128'd0);
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;

      // Stream rd 1..4 with no back-pressure: one cycle latency, no gaps
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 5'(i), 5'd20, 5'd21, 2'b00, 1'b1, 1'b0);
         check("stream_ready", {127'd0, in_ready_o}, 128'd1);
         step();
         check("stream_valid", {127'd0, out_valid_o}, 128'd1);
         check("stream_rd",    {123'd0, RDaddr_o},    128'(i));
      end
      idle(1'b1); step();
      check("stream_drain", {127'd0, out_valid_o}, 128'd0);

      // Mid-stream reset: loses the held entry immediately
      drive(1'b1, 5'd12, 5'd20, 5'd21, 2'b01, 1'b0, 1'b0); step();
      check("pre_rst_valid", {127'd0, out_valid_o}, 128'd1);
      rst_n_i = 1'b0;
      #1;
      check("arst_valid",   {127'd0, out_valid_o}, 128'd0);
      check("arst_ready",   {127'd0, in_ready_o},  128'd1);
      check("arst_outputs", out_vec, 128'd0);
      sb.delete();
      idle(1'b1);
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;

      // Back-pressure: main holds 5, skid takes 6
      drive(1'b1, 5'd5, 5'd20, 5'd21, 2'b00, 1'b0, 1'b0); step();
      check("bp_ready1", {127'd0, in_ready_o}, 128'd1);
      drive(1'b1, 5'd6, 5'd20, 5'd21, 2'b00, 1'b0, 1'b0); step();
      check("bp_ready2", {127'd0, in_ready_o}, 128'd0);
      check("bp_hold1",  {123'd0, RDaddr_o},   128'd5);
      drive(1'b1, 5'd6, 5'd20, 5'd21, 2'b00, 1'b0, 1'b0); step();
      check("bp_ready3", {127'd0, in_ready_o}, 128'd0);
      check("bp_hold2",  {123'd0, RDaddr_o},   128'd5);
      idle(1'b1); step();
      check("bp_rel_valid", {127'd0, out_valid_o}, 128'd1);
      check("bp_rel_rd",    {123'd0, RDaddr_o},    128'd6);
      check("bp_rel_ready", {127'd0, in_ready_o},  128'd1);
      idle(1'b1); step();
      check("bp_drain", {127'd0, out_valid_o}, 128'd0);

      // Flush with both entries full and a pending input (rd 7)
      drive(1'b1, 5'd8, 5'd20, 5'd21, 2'b00, 1'b0, 1'b0); step();
      drive(1'b1, 5'd9, 5'd20, 5'd21, 2'b00, 1'b0, 1'b0); step();
      check("fl_full", {127'd0, in_ready_o}, 128'd0);
      drive(1'b1, 5'd7, 5'd20, 5'd21, 2'b10, 1'b0, 1'b1); step();
      check("fl_valid", {127'd0, out_valid_o}, 128'd0);
      check("fl_ready", {127'd0, in_ready_o},  128'd1);
      idle(1'b1); step();
      check("fl_empty", {127'd0, out_valid_o}, 128'd0);
      // Flush while an input is actually accepted: it must be discarded
      drive(1'b1, 5'd10, 5'd20, 5'd21, 2'b00, 1'b1, 1'b0); step();
      drive(1'b1, 5'd7,  5'd20, 5'd21, 2'b10, 1'b1, 1'b1); step();
      check("fl2_valid", {127'd0, out_valid_o}, 128'd0);
      idle(1'b1); step();
      check("fl2_never7", {127'd0, out_valid_o}, 128'd0);

      // Load-use: load rd=3 then consumer with RS2addr=3
      drive(1'b1, 5'd3, 5'd1, 5'd2, 2'b10, 1'b1, 1'b0); step();
      drive(1'b1, 5'd11, 5'd4, 5'd3, 2'b00, 1'b1, 1'b0);
`ifdef ID_EX_LOAD_USE_DETECT_EN
      check("lu_hazard", {127'd0, hazard_o},   128'd1);
      check("lu_stall",  {127'd0, in_ready_o}, 128'd0);
      step();
      check("lu_bubble",   {127'd0, out_valid_o}, 128'd0);
      check("lu_hz_clear", {127'd0, hazard_o},    128'd0);
      step();
      check("lu_after_valid", {127'd0, out_valid_o}, 128'd1);
      check("lu_after_rd",    {123'd0, RDaddr_o},    128'd11);
`else
      check("lu_hazard", {127'd0, hazard_o},   128'd0);
      check("lu_ready",  {127'd0, in_ready_o}, 128'd1);
      step();
      check("lu_nobubble", {127'd0, out_valid_o}, 128'd1);
      check("lu_rd",       {123'd0, RDaddr_o},    128'd11);
`endif
      idle(1'b1); step();

      // Load to x0 followed by RS1addr=0: never a hazard
      drive(1'b1, 5'd0, 5'd1, 5'd2, 2'b10, 1'b1, 1'b0); step();
      drive(1'b1, 5'd13, 5'd0, 5'd2, 2'b00, 1'b1, 1'b0);
      check("x0_hazard", {127'd0, hazard_o},   128'd0);
      check("x0_ready",  {127'd0, in_ready_o}, 128'd1);
      step();
      check("x0_rd", {123'd0, RDaddr_o}, 128'd13);
      idle(1'b1); step();
      idle(1'b1); step();

      check("sb_drained", 128'(sb.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register with a valid/ready handshake.
- Built around a 2-entry skid buffer, so upstream ready depends on registered state only.
- Supports flush and bubble insertion.
- Sits between decode and execute. Successor to the fixed-width, always-advancing ID/EX latch.

Parameters:
DATA_W, 32, width of RS1/RS2 operand and immediate fields
REG_AW, 5, register-address width
FUNCT_W, 10, funct field width (funct7 + funct3)
WB_W, 2, write-back control width (bit0 RegWrite, bit1 MemtoReg)
MEM_W, 2, memory control width (bit0 MemWrite, bit MEM_W-1 MemRead)
EX_W, 3, execute control width (bit0 ALUSrc, bits EX_W-1:1 ALUOp)

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous kill of all held entries (branch taken / exception)
in_valid_i  in  1  decode presents a valid instruction
in_ready_o  out  1  stage can accept this cycle
WB_i  in  WB_W  write-back control
MEM_i  in  MEM_W  memory control
EX_i  in  EX_W  execute control
RS1_i, RS2_i, IMM_i  in  DATA_W each  operands and immediate
RS1addr_i, RS2addr_i, RDaddr_i  in  REG_AW each  register addresses
funct_i  in  FUNCT_W  funct bits
out_valid_o  out  1  execute-side entry valid
out_ready_i  in  1  execute consumes this cycle
WB_o, MEM_o  out  WB_W / MEM_W  controls; forced 0 when out_valid_o=0
ALUSrc_o  out  1  EX[0]; forced 0 when invalid
ALUOp_o  out  EX_W-1  EX[EX_W-1:1]; forced 0 when invalid
RS1_o, RS2_o, IMM_o, RS1addr_o, RS2addr_o, RDaddr_o, funct_o  out  as inputs  held payload
hazard_o  out  1  load-use stall indication (see Optional Feature)

Behaviour:
- Storage: main register (drives outputs) and skid register, each with its own valid bit (main_v, skid_v).
- in_fire = in_valid_i & in_ready_o.
- out_fire = out_valid_o & out_ready_i.
- in_ready_o = ~skid_v, gated by hazard when the macro is enabled.
- out_valid_o = main_v.
- Reset (async, rst_n_i low): main_v = skid_v = 0, all payload registers = 0.
  - Consequences: every output reads 0; in_ready_o = 1.
- Latency: an accepted entry appears at the outputs 1 cycle after in_fire when main is empty or is draining that cycle.
- Per-cycle update when flush_i = 0:
  - main empty or out_fire, skid_v = 1: skid moves into main. If in_fire, the input goes to main instead only when skid is empty; otherwise in_ready_o = 0, so no input arrives.
  - main empty or out_fire, skid_v = 0: main <- input if in_fire, else main_v <- 0.
  - main_v = 1, no out_fire, in_fire: input goes to skid (skid_v <- 1).
  - Ordering is strict FIFO. No entry is dropped or duplicated.
- Flush:
  - flush_i = 1 sets main_v = skid_v = 0 at the next edge, regardless of out_ready_i and in_valid_i.
  - A concurrent input is discarded.
  - Payload registers may keep stale data; controls still read 0 through output gating.
- Bubble:
  - When out_valid_o = 0, WB_o, MEM_o, ALUSrc_o and ALUOp_o are 0.
  - Downstream therefore never writes the register file or memory from a bubble.
- Back-pressure:
  - out_ready_i low with main_v = 1 holds all outputs stable.
  - A second accepted input fills skid; in_ready_o drops the following cycle.
- Simultaneous out_fire and in_fire with both entries full cannot occur, because in_ready_o = 0 in that state.
- Reset mid-operation: both entries are lost immediately (asynchronous); no partial state survives.

Optional Feature:
- Macro: ID_EX_LOAD_USE_DETECT_EN.
- Enabled:
  - hazard_o = in_valid_i & main_v & MEM_o[MEM_W-1] & (RDaddr_o != 0) & (RDaddr_o == RS1addr_i | RDaddr_o == RS2addr_i).
  - in_ready_o = ~skid_v & ~hazard_o.
  - Effect: a dependent instruction is held in decode until the load leaves main, inserting exactly one bubble when out_ready_i = 1.
- Disabled:
  - hazard_o tied to 0; in_ready_o = ~skid_v.
  - Hazard handling is left to the external unit.

Test Plan:
- Reset with rst_n_i=0 mid-stream, then release → out_valid_o=0, WB_o=0, MEM_o=0, in_ready_o=1 immediately on assertion.
- Stream 4 instructions, RDaddr 1..4, with out_ready_i=1 → each appears 1 cycle later, in order, with no gaps.
- out_ready_i=0 for 3 cycles while in_valid_i=1 with RDaddr 5,6 → main holds 5, skid takes 6, in_ready_o=0 from cycle 2; on release, 5 then 6 emerge in consecutive cycles.
- flush_i=1 with both entries full and in_valid_i=1 (RDaddr 7) → next cycle out_valid_o=0, controls 0; entry 7 never appears.
- Load (MEM_i=2'b10, RDaddr=3) followed by an instruction with RS2addr=3, macro enabled → hazard_o=1 for 1 cycle and one bubble with out_valid_o=0. With macro disabled → no bubble, hazard_o=0.
- Load with RDaddr=0 followed by RS1addr=0, macro enabled → hazard_o stays 0.
